// File: rtl/instruction_fetch_unit_pkg.sv
// CPU_package: shared widths, the HALT opcode and the fetch buffer entry type
// used by the instruction fetch unit, its bus interface and its buffer.
//   DATA_WIDTH     instruction word width (16)
//   ALU_OPCODE     opcode field width, top bits of the instruction (4)
//   IM_ADDR_WIDTH  instruction memory address width (11)
//   OP_HALT        opcode that stops fetching when HALT_DETECT_EN is defined
//   fetch_entry_t  {instr, pc} pair carried from IM capture to decode
package CPU_package;

  localparam int DATA_WIDTH    = 16;
  localparam int ALU_OPCODE    = 4;
  localparam int IM_ADDR_WIDTH = DATA_WIDTH - ALU_OPCODE - 1;

  localparam logic [ALU_OPCODE-1:0] OP_HALT = 4'hF;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    instr;
    logic [IM_ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;

  // Opcode lives in the top ALU_OPCODE bits of the instruction word.
  function automatic logic isHalt(input logic [DATA_WIDTH-1:0] word);
    return word[DATA_WIDTH-1 -: ALU_OPCODE] == OP_HALT;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: groups the instruction memory read port and the
// decode valid/ready handshake of the fetch stage.
//   address_IM   IM read address (fetch -> IM)
//   out_IM       IM read data, one cycle after address_IM (IM -> fetch)
//   instr        instruction at buffer head (fetch -> decode)
//   instr_pc     address instr was fetched from (fetch -> decode)
//   instr_valid  instr/instr_pc valid (fetch -> decode)
//   instr_ready  decode accepts (decode -> fetch)
// Modports: master = fetch unit side, slave = memory/decode side.
interface instruction_fetch_unit_if;
  import CPU_package::*;

  logic [IM_ADDR_WIDTH-1:0] address_IM;
  logic [DATA_WIDTH-1:0]    out_IM;
  logic [DATA_WIDTH-1:0]    instr;
  logic [IM_ADDR_WIDTH-1:0] instr_pc;
  logic                     instr_valid;
  logic                     instr_ready;

  modport master (
    output address_IM, instr, instr_pc, instr_valid,
    input  out_IM, instr_ready
  );

  modport slave (
    input  address_IM, instr, instr_pc, instr_valid,
    output out_IM, instr_ready
  );

endinterface

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// fetch_buffer: 2-entry in-order FIFO of fetch_entry_t between IM capture and
// decode. Head is always entry0, so the head outputs come straight from flops.
//   clk, rst_n   clock, asynchronous active-low reset
//   push_i       write entry_i at the tail
//   entry_i      {instr, pc} to store
//   pop_i        remove head (ignored when empty)
//   flush_i      discard everything; wins over push and pop
//   head_o       head entry
//   count_o      number of valid entries (0..2)
module fetch_buffer
  import CPU_package::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  fetch_entry_t entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

  fetch_entry_t entry0_q, entry0_d;
  fetch_entry_t entry1_q, entry1_d;
  logic [1:0]   count_q, count_d;
  logic         doPop, doPush;

  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    count_d  = count_q;
    doPop    = pop_i && (count_q != 2'd0);
    // A push into a full buffer is only legal when the head leaves the same cycle.
    doPush   = push_i && ((count_q != 2'd2) || doPop);
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({doPush, doPop})
        2'b10: begin
          if (count_q == 2'd0) entry0_d = entry_i;
          else                 entry1_d = entry_i;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          entry0_d = entry1_q;
          count_d  = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            entry0_d = entry_i;
          end else begin
            entry0_d = entry1_q;
            entry1_d = entry_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry0_q <= '0;
      entry1_q <= '0;
      count_q  <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = entry0_q;
  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetch stage in front of a synchronous instruction
// memory. Owns the PC, issues one IM read per cycle while buffer credit allows,
// captures out_IM a cycle later and hands {instr, pc} to decode.
//   clk, rst_n      clock, asynchronous active-low reset
//   en              fetch enable; 0 stops new reads (in-flight read still lands)
//   branch_taken    redirect pulse; flushes buffer and squashes in-flight read
//   branch_target   new PC, sampled with branch_taken
//   halted          HALT opcode seen (only with HALT_DETECT_EN, else 0)
//   fetch_bus       instruction_fetch_unit_if.master: IM port + decode handshake
// Optional feature macro: HALT_DETECT_EN enables HALT opcode detection.
module instruction_fetch_unit
  import CPU_package::*;
#(
  parameter logic [IM_ADDR_WIDTH-1:0] RESET_PC  = 11'h000,
  parameter int                       BUF_DEPTH = 2  // only 2 is supported
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     branch_taken,
  input  logic [IM_ADDR_WIDTH-1:0] branch_target,
  output logic                     halted,
  instruction_fetch_unit_if.master fetch_bus
);

  localparam logic [2:0] DepthLimit = 3'(BUF_DEPTH);

  logic [IM_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [IM_ADDR_WIDTH-1:0] inflightPc_q, inflightPc_d;
  logic                     inflight_q, inflight_d;

  fetch_entry_t headEntry;
  fetch_entry_t captureEntry;
  logic [1:0]   bufCount;
  logic         instrValid;
  logic         pop, push, issue;
  logic [2:0]   occupancy;
  logic         haltedNow;

  assign instrValid = (bufCount != 2'd0);
  assign pop        = instrValid & fetch_bus.instr_ready;

  // Slots committed after this edge: buffered + in flight - leaving. Issuing
  // only below the buffer depth guarantees every in-flight read has a home.
  assign occupancy = {1'b0, bufCount} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = en & ~haltedNow & ~branch_taken & (occupancy < DepthLimit);

  // Once halted, a read issued alongside the HALT push is dropped on arrival.
  assign push = inflight_q & ~branch_taken & ~haltedNow;

  assign captureEntry.instr = fetch_bus.out_IM;
  assign captureEntry.pc    = inflightPc_q;

  always_comb begin
    pc_d         = pc_q;
    inflightPc_d = inflightPc_q;
    inflight_d   = issue;
    if (branch_taken) begin
      pc_d = branch_target;
    end else if (issue) begin
      pc_d         = pc_q + 1'b1;
      inflightPc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      inflightPc_q <= '0;
      inflight_q   <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      inflightPc_q <= inflightPc_d;
      inflight_q   <= inflight_d;
    end
  end

`ifdef HALT_DETECT_EN
  logic halted_q, halted_d;

  always_comb begin
    halted_d = halted_q;
    if (branch_taken) begin
      halted_d = 1'b0;
    end else if (push && isHalt(fetch_bus.out_IM)) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign haltedNow = halted_q;
`else
  assign haltedNow = 1'b0;
`endif

  fetch_buffer u_fetch_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .entry_i (captureEntry),
    .pop_i   (pop),
    .flush_i (branch_taken),
    .head_o  (headEntry),
    .count_o (bufCount)
  );

  assign fetch_bus.address_IM  = pc_q;
  assign fetch_bus.instr       = headEntry.instr;
  assign fetch_bus.instr_pc    = headEntry.pc;
  assign fetch_bus.instr_valid = instrValid;
  assign halted                = haltedNow;

endmodule
